bcd_seg7_scan: RTL and testbench

- Downstream consumer of the BCD seconds counter: takes packed BCD digits and drives a multiplexed common-anode/common-cathode seven-segment display.
- Latches a new value only at frame boundaries, so a digit never changes part-way through a scan (no tearing).
- Scans one digit at a time with an anode-off blanking gap between digits (ghost suppression).
- Decodes BCD to segments, optionally blanks leading zeros, and passes per-digit decimal points through.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 11 +
 rtl/bcd_seg7_scan.sv | 157 +++++++++++++++
 tb/tb_bcd_seg7_scan.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display: scan states
// and the active-high {g,f,e,d,c,b,a} segment codes for every 4-bit input.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg7_state_e;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    // Codes 10..15 are not BCD and render as a dash.
    localparam logic [15:0][6:0] SEG_CODE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high segment pattern decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_CODE[bcd_i];

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed seven-segment scanner: frame-synchronous BCD capture, one digit
// lit at a time with an all-off gap between digits, optional leading-zero blanking.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  bcd_load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output seg7_state_e           state_dbg
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int PW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_INACT = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic              DP_INACT  = COMMON_ANODE;
    localparam logic [DIGITS-1:0] AN_INACT  = COMMON_ANODE ? {DIGITS{1'b1}} : '0;

    seg7_state_e         state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_bcd_q, pend_bcd_d, shad_bcd_q, shad_bcd_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    // bcd_load is a single-cycle strobe with no back-pressure: every cycle it
    // is high, {bcd_in, dp_in} is taken into the pending register.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q + 1'b1;
        idx_d      = idx_q;
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        shad_bcd_d = shad_bcd_q;
        shad_dp_d  = shad_dp_q;
        if (bcd_load) begin
            pend_bcd_d = bcd_in;
            pend_dp_d  = dp_in;
        end
        case (state_q)
            ST_BLANK: begin
                if (presc_q == PW'(BLANK_CYC - 1)) begin
                    state_d = ST_SHOW;
                    presc_d = '0;
                end
            end
            ST_SHOW: begin
                if (presc_q == PW'(SCAN_DIV - 1)) begin
                    state_d = ST_BLANK;
                    presc_d = '0;
                    if (idx_q == IW'(DIGITS - 1)) begin
                        idx_d = '0;
                        // Committing the _d copy lets a same-edge load bypass into the shadow.
                        shad_bcd_d = pend_bcd_d;
                        shad_dp_d  = pend_dp_d;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                presc_d = '0;
            end
        endcase
    end

    logic [3:0]        dig [DIGITS];
    logic [DIGITS-1:0] hi_zero;
    logic [DIGITS-1:0] an_hot;
    logic [3:0]        sel_bcd;
    logic [6:0]        dec_seg;
    logic [6:0]        lit_seg;
    logic              run_zero;
    logic              show;

    // Outputs are derived from next-state values so they change on the very
    // edge the FSM enters a state.
    always_comb begin
        run_zero = 1'b1;
        hi_zero  = '0;
        an_hot   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig[i] = shad_bcd_d[4*i +: 4];
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero & (dig[i] == 4'd0);
            hi_zero[i] = run_zero;
        end
        an_hot[idx_d] = 1'b1;
        sel_bcd       = dig[idx_d];
    end

    bcd_to_seg7 u_dec (
        .bcd_i (sel_bcd),
        .seg_o (dec_seg)
    );

    always_comb begin
        show    = (state_d == ST_SHOW);
        lit_seg = (blank_lz && (idx_d != '0) && hi_zero[idx_d]) ? SEG_OFF : dec_seg;
        seg_d   = show ? lit_seg : SEG_OFF;
        dp_d    = show & shad_dp_d[idx_d];
        an_d    = show ? an_hot : '0;
        if (COMMON_ANODE) begin
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
            an_d  = ~an_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            presc_q    <= '0;
            idx_q      <= '0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            shad_bcd_q <= '0;
            shad_dp_q  <= '0;
            seg_q      <= SEG_INACT;
            dp_q       <= DP_INACT;
            an_q       <= AN_INACT;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            shad_bcd_q <= shad_bcd_d;
            shad_dp_q  <= shad_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Bench for bcd_seg7_scan with a 4-digit, SCAN_DIV=4, BLANK_CYC=1 common-anode display.
module tb_bcd_seg7_scan;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        bcd_load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    seg7_state_e state_dbg;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    bcd_seg7_scan #(
        .DIGITS       (4),
        .SCAN_DIV     (4),
        .BLANK_CYC    (1),
        .COMMON_ANODE (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .bcd_load  (bcd_load),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .state_dbg (state_dbg)
    );

    // Reference model: position in the 20-cycle frame counted from reset release.
    logic [6:0]  seg_tab [16];
    int unsigned k;
    logic [15:0] m_pend, m_shad;
    logic [3:0]  m_pdp, m_sdp;
    logic [15:0] cur_bcd = '0;
    logic [3:0]  cur_dp = '0;
    logic        cur_blz = 1'b0;
    logic [12:0] exp_q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    // driver task: one clock cycle, model update, scoreboard compare
    task automatic step(input logic r, input logic ld);
        logic [12:0] e;
        logic [12:0] act;
        logic [15:0] upper;
        logic [6:0]  s;
        logic [3:0]  an_e;
        int p, dg;
        @(negedge clk);
        rst      = r;
        bcd_load = ld;
        bcd_in   = cur_bcd;
        dp_in    = cur_dp;
        blank_lz = cur_blz;
        @(posedge clk);
        e = {1'b0, 4'hF, 7'h7F, 1'b1};
        if (r) begin
            k = 0;
            m_pend = '0; m_shad = '0; m_pdp = '0; m_sdp = '0;
        end else begin
            k++;
            if (ld) begin
                m_pend = cur_bcd;
                m_pdp  = cur_dp;
            end
            if (k % 20 == 0) begin
                m_shad = m_pend;
                m_sdp  = m_pdp;
            end
            p  = int'((k - 1) % 20);
            dg = p / 5;
            if (p % 5 < 4) begin
                upper = m_shad >> (4 * dg);
                s = seg_tab[upper[3:0]];
                if (cur_blz && dg > 0 && upper == 16'h0) s = 7'h00;
                an_e = 4'b0001 << dg;
                e = {1'b1, ~an_e, ~s, ~m_sdp[dg]};
            end
        end
        exp_q.push_back(e);
        #1;
        act = {state_dbg == ST_SHOW, an, seg, dp};
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL scan k=%0d actual={st,an,seg,dp}=%h expected=%h", k, act, e);
        end
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic        blz;
        int          digit;
        logic [6:0]  seg_e;
        logic        dp_e;
    } vec_t;

    vec_t vec [15];

    initial begin
        logic [3:0] an_exp;
        logic [3:0] one;

        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                    7'b1000000};
        vec[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 7'h19, 1'b1};
        vec[1]  = '{16'h1234, 4'b0000, 1'b0, 1, 7'h30, 1'b1};
        vec[2]  = '{16'h1234, 4'b0000, 1'b0, 2, 7'h24, 1'b1};
        vec[3]  = '{16'h1234, 4'b0000, 1'b0, 3, 7'h79, 1'b1};
        vec[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 7'h7F, 1'b1};
        vec[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 7'h7F, 1'b1};
        vec[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 7'h12, 1'b1};
        vec[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 7'h40, 1'b1};
        vec[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h40, 1'b1};
        vec[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'h7F, 1'b1};
        vec[10] = '{16'h0000, 4'b0000, 1'b1, 3, 7'h7F, 1'b1};
        vec[11] = '{16'h00A0, 4'b0010, 1'b0, 1, 7'h3F, 1'b0};
        vec[12] = '{16'h00A0, 4'b0010, 1'b0, 0, 7'h40, 1'b1};
        vec[13] = '{16'h00A0, 4'b0010, 1'b0, 2, 7'h40, 1'b1};
        vec[14] = '{16'h0A00, 4'b1000, 1'b1, 1, 7'h40, 1'b1};
        k = 0;
        one = 4'b0001;

        // reset held three cycles, then first SHOW one cycle after release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("reset_an", 16'(an), 16'hF);
            chk("reset_seg", 16'(seg), 16'h7F);
            chk("reset_dp", 16'(dp), 16'h1);
        end
        step(1'b0, 1'b0);
        chk("first_show_an", 16'(an), 16'hE);
        chk("first_show_seg", 16'(seg), 16'h40);

        // table-driven decode / blanking / dp vectors
        for (int t = 0; t < 15; t++) begin
            cur_bcd = vec[t].bcd;
            cur_dp  = vec[t].dpv;
            cur_blz = vec[t].blz;
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            repeat (19) step(1'b0, 1'b0);
            repeat (1 + 5 * vec[t].digit) step(1'b0, 1'b0);
            an_exp = ~(one << vec[t].digit);
            chk("vec_an", 16'(an), 16'(an_exp));
            chk("vec_seg", 16'(seg), 16'(vec[t].seg_e));
            chk("vec_dp", 16'(dp), 16'(vec[t].dp_e));
        end

        // frame-boundary commit: mid-frame load must not tear the frame
        cur_bcd = 16'h1111; cur_dp = 4'h0; cur_blz = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (19) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        cur_bcd = 16'h2222;
        step(1'b0, 1'b1);
        chk("commit_d1_old", 16'(seg), 16'h79);
        repeat (5) step(1'b0, 1'b0);
        chk("commit_d2_old", 16'(seg), 16'h79);
        repeat (5) step(1'b0, 1'b0);
        chk("commit_d3_old", 16'(seg), 16'h79);
        repeat (5) step(1'b0, 1'b0);
        chk("commit_d0_new_an", 16'(an), 16'hE);
        chk("commit_d0_new_seg", 16'(seg), 16'h24);
        // load on the exact wrap edge bypasses into the next frame
        repeat (18) step(1'b0, 1'b0);
        cur_bcd = 16'h3333;
        step(1'b0, 1'b1);
        chk("wrap_edge_blank", 16'(an), 16'hF);
        step(1'b0, 1'b0);
        chk("wrap_load_seg", 16'(seg), 16'h30);

        // reset mid-scan during digit2 SHOW
        repeat (10) step(1'b0, 1'b0);
        chk("mid_d2_an", 16'(an), 16'hB);
        step(1'b1, 1'b0);
        chk("mid_rst_an", 16'(an), 16'hF);
        chk("mid_rst_seg", 16'(seg), 16'h7F);
        step(1'b0, 1'b0);
        chk("mid_restart_an", 16'(an), 16'hE);
        chk("mid_restart_seg", 16'(seg), 16'h40);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic r, ld;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            if (ld) begin
                for (int n = 0; n < 4; n++) begin
                    cur_bcd[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                cur_dp = 4'($urandom);
            end
            if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
            step(r, ld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
